instr_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 30 +++
 rtl/instr_fetch_unit_if.sv | 36 +++
 rtl/fetch_timeout_ctr.sv | 29 ++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and the opcode set understood by the control unit.
package fetch_pkg;

    localparam logic [6:0] OP_R    = 7'd51;
    localparam logic [6:0] OP_ADDI = 7'd19;
    localparam logic [6:0] OP_LD   = 7'd3;
    localparam logic [6:0] OP_SD   = 7'd35;
    localparam logic [6:0] OP_BEQ  = 7'd99;
    localparam logic [6:0] OP_BNE  = 7'd103;
    localparam logic [6:0] OP_LUI  = 7'd55;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StDone  = 2'd2,
        StFault = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        CauseNone     = 2'd0,
        CauseMisalign = 2'd1,
        CauseTimeout  = 2'd2
    } fault_cause_e;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R)   || (op == OP_ADDI) || (op == OP_LD)  || (op == OP_SD) ||
               (op == OP_BEQ) || (op == OP_BNE)  || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch command, instruction-memory and decoded-field signals of instr_fetch_unit.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              FETCH_START;
    logic [ADDR_W-1:0] PC_IN;
    logic              FAULT_CLR;
    logic              IMEM_REQ;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic              IMEM_ACK;
    logic [31:0]       IMEM_RDATA;
    logic [31:0]       IR31_0;
    logic [6:0]        IR6_0;
    logic [4:0]        IR11_7;
    logic [4:0]        IR19_15;
    logic [4:0]        IR24_20;
    logic [6:0]        FUNCT7;
    logic              IR_VALID;
    logic              ILLEGAL_OP;
    logic              BUSY;
    logic              FETCH_FAULT;
    logic [1:0]        FAULT_CAUSE;

    modport master (
        output FETCH_START, PC_IN, FAULT_CLR, IMEM_ACK, IMEM_RDATA,
        input  IMEM_REQ, IMEM_ADDR, IR31_0, IR6_0, IR11_7, IR19_15, IR24_20, FUNCT7,
        input  IR_VALID, ILLEGAL_OP, BUSY, FETCH_FAULT, FAULT_CAUSE
    );

    modport slave (
        input  FETCH_START, PC_IN, FAULT_CLR, IMEM_ACK, IMEM_RDATA,
        output IMEM_REQ, IMEM_ADDR, IR31_0, IR6_0, IR11_7, IR19_15, IR24_20, FUNCT7,
        output IR_VALID, ILLEGAL_OP, BUSY, FETCH_FAULT, FAULT_CAUSE
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// Request-wait counter; o_expire flags the last permitted REQ cycle without an ack.
module fetch_timeout_ctr #(
    parameter int unsigned LIMIT = 15
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int unsigned CntW = $clog2(LIMIT + 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    // The count reaches LIMIT on the same edge the FSM leaves REQ.
    assign o_expire = i_en && (r_cnt == CntW'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch into the IR with misalignment fault reporting.
// Optional memory timeout fault enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic                CLK,
    input logic                RESET,
    instr_fetch_unit_if.slave  bus
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_ir;
    logic              r_illegal;
    fault_cause_e      r_cause;

    logic w_start_ok;
    logic w_misalign;
    logic w_capture;
    logic w_timeout;
    logic w_clear;
    logic w_expire;
    logic w_in_req;

    assign w_in_req = (r_state == StReq);

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_clr    (!w_in_req),
        .i_en     (w_in_req && !bus.IMEM_ACK),
        .o_expire (w_expire)
    );
`else
    logic w_tmo_unused;
    assign w_tmo_unused = ^TIMEOUT_CYCLES;
    assign w_expire     = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_misalign   = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_clear      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.FETCH_START) begin
                    if (bus.PC_IN[1:0] == 2'b00) begin
                        w_start_ok   = 1'b1;
                        w_state_next = StReq;
                    end else begin
                        w_misalign   = 1'b1;
                        w_state_next = StFault;
                    end
                end
            end
            StReq: begin
                // Ack takes priority over an expiry in the same cycle.
                if (bus.IMEM_ACK) begin
                    w_capture    = 1'b1;
                    w_state_next = StDone;
                end else if (w_expire) begin
                    w_timeout    = 1'b1;
                    w_state_next = StFault;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            StFault: begin
                if (bus.FAULT_CLR) begin
                    w_clear      = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr    <= '0;
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_cause   <= CauseNone;
        end else begin
            if (w_start_ok) begin
                r_addr <= bus.PC_IN;
            end
            if (w_capture) begin
                r_ir      <= bus.IMEM_RDATA;
                r_illegal <= !is_legal_op(bus.IMEM_RDATA[6:0]);
            end
            if (w_misalign) begin
                r_cause <= CauseMisalign;
            end else if (w_timeout) begin
                r_cause <= CauseTimeout;
            end else if (w_clear) begin
                r_cause <= CauseNone;
            end
        end
    end

    assign bus.IMEM_REQ    = w_in_req;
    assign bus.IMEM_ADDR   = r_addr;
    assign bus.IR31_0      = r_ir;
    assign bus.IR6_0       = r_ir[6:0];
    assign bus.IR11_7      = r_ir[11:7];
    assign bus.IR19_15     = r_ir[19:15];
    assign bus.IR24_20     = r_ir[24:20];
    assign bus.FUNCT7      = r_ir[31:25];
    assign bus.IR_VALID    = (r_state == StDone);
    assign bus.ILLEGAL_OP  = r_illegal;
    assign bus.BUSY        = (r_state != StIdle);
    assign bus.FETCH_FAULT = (r_state == StFault);
    assign bus.FAULT_CAUSE = r_cause;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit against a transaction-level model.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned TMO    = 15;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_unit #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the last instruction word accepted and its legality.
    logic [31:0] m_ir      = '0;
    logic        m_illegal = 1'b0;
    int          legal_ops[7] = '{51, 19, 3, 35, 99, 103, 55};

    function automatic logic op_illegal(input logic [31:0] w);
        for (int i = 0; i < 7; i++) begin
            if (int'(w[6:0]) == legal_ops[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ir(input string tag);
        check_eq({tag, ".ir"},      bus.IR31_0,     m_ir);
        check_eq({tag, ".op"},      bus.IR6_0,      m_ir[6:0]);
        check_eq({tag, ".rd"},      bus.IR11_7,     m_ir[11:7]);
        check_eq({tag, ".rs1"},     bus.IR19_15,    m_ir[19:15]);
        check_eq({tag, ".rs2"},     bus.IR24_20,    m_ir[24:20]);
        check_eq({tag, ".funct7"},  bus.FUNCT7,     m_ir[31:25]);
        check_eq({tag, ".illegal"}, bus.ILLEGAL_OP, m_illegal);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".req"},   bus.IMEM_REQ,    1'b0);
        check_eq({tag, ".busy"},  bus.BUSY,        1'b0);
        check_eq({tag, ".fault"}, bus.FETCH_FAULT, 1'b0);
        check_eq({tag, ".valid"}, bus.IR_VALID,    1'b0);
    endtask

    task automatic capture_and_finish(input string tag, input logic [31:0] data);
        bus.FETCH_START = 1'b0;
        bus.IMEM_ACK    = 1'b1;
        bus.IMEM_RDATA  = data;
        step();
        bus.IMEM_ACK = 1'b0;
        m_ir      = data;
        m_illegal = op_illegal(data);
        check_eq({tag, ".valid1"}, bus.IR_VALID, 1'b1);
        check_eq({tag, ".reqlow"}, bus.IMEM_REQ, 1'b0);
        check_eq({tag, ".busyd"},  bus.BUSY,     1'b1);
        check_ir(tag);
        step();
        check_eq({tag, ".valid0"}, bus.IR_VALID, 1'b0);
        check_eq({tag, ".busy0"},  bus.BUSY,     1'b0);
        check_ir({tag, ".hold"});
    endtask

    // Aligned fetch: ack arrives after wait_cycles REQ cycles without one.
    task automatic fetch_ok(input string tag, input logic [63:0] pc, input int wait_cycles,
                            input logic [31:0] data);
        bus.PC_IN       = pc;
        bus.FETCH_START = 1'b1;
        step();
        bus.FETCH_START = 1'b0;
        check_eq({tag, ".req1"},  bus.IMEM_REQ,  1'b1);
        check_eq({tag, ".addr"},  bus.IMEM_ADDR, pc);
        check_eq({tag, ".busy1"}, bus.BUSY,      1'b1);
        check_eq({tag, ".nv"},    bus.IR_VALID,  1'b0);
        for (int i = 0; i < wait_cycles; i++) begin
            bus.FETCH_START = 1'($urandom_range(0, 1));
            bus.PC_IN       = {$urandom, $urandom};
            bus.IMEM_RDATA  = $urandom;
            step();
            check_eq({tag, ".wreq"},  bus.IMEM_REQ,  1'b1);
            check_eq({tag, ".waddr"}, bus.IMEM_ADDR, pc);
            check_eq({tag, ".wir"},   bus.IR31_0,    m_ir);
            check_eq({tag, ".wv"},    bus.IR_VALID,  1'b0);
        end
        capture_and_finish(tag, data);
    endtask

    task automatic fetch_misaligned(input string tag, input logic [63:0] pc);
        logic [63:0] prev_addr;
        prev_addr       = bus.IMEM_ADDR;
        bus.PC_IN       = pc;
        bus.FETCH_START = 1'b1;
        step();
        bus.FETCH_START = 1'b0;
        check_eq({tag, ".fault"}, bus.FETCH_FAULT, 1'b1);
        check_eq({tag, ".cause"}, bus.FAULT_CAUSE, 2'd1);
        check_eq({tag, ".req"},   bus.IMEM_REQ,    1'b0);
        check_eq({tag, ".busy"},  bus.BUSY,        1'b1);
        check_eq({tag, ".ir"},    bus.IR31_0,      m_ir);
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            bus.FETCH_START = 1'b1;
            bus.PC_IN       = {$urandom, $urandom} & ~64'h3;
            bus.IMEM_ACK    = 1'($urandom_range(0, 1));
            bus.IMEM_RDATA  = $urandom;
            step();
            check_eq({tag, ".stay"},  bus.FETCH_FAULT, 1'b1);
            check_eq({tag, ".sreq"},  bus.IMEM_REQ,    1'b0);
            check_eq({tag, ".saddr"}, bus.IMEM_ADDR,   prev_addr);
        end
        bus.FETCH_START = 1'b0;
        bus.IMEM_ACK    = 1'b0;
        bus.FAULT_CLR   = 1'b1;
        step();
        bus.FAULT_CLR = 1'b0;
        check_idle({tag, ".clr"});
        check_eq({tag, ".cause0"}, bus.FAULT_CAUSE, 2'd0);
        check_ir({tag, ".clr"});
    endtask

    task automatic check_all_zero(input string tag);
        check_idle(tag);
        check_eq({tag, ".addr"},  bus.IMEM_ADDR,   '0);
        check_eq({tag, ".cause"}, bus.FAULT_CAUSE, 2'd0);
        check_ir(tag);
    endtask

    initial begin
        logic [63:0] pc;
        logic [31:0] data;
        int          w;

        bus.FETCH_START = 1'b0;
        bus.PC_IN       = '0;
        bus.FAULT_CLR   = 1'b0;
        bus.IMEM_ACK    = 1'b0;
        bus.IMEM_RDATA  = '0;
        step();
        step();
        check_all_zero("rst");
        RESET = 1'b0;
        step();
        check_all_zero("post_rst");

        // Directed: ack two cycles after REQ rises.
        fetch_ok("addi", 64'h40, 2, 32'h00A00093);
        check_eq("addi.op_k",  bus.IR6_0,      7'd19);
        check_eq("addi.rd_k",  bus.IR11_7,     5'd1);
        check_eq("addi.rs1_k", bus.IR19_15,    5'd0);
        check_eq("addi.ill_k", bus.ILLEGAL_OP, 1'b0);
        check_eq("addi.adr_k", bus.IMEM_ADDR,  64'h40);

        // Directed: ack already high when the start arrives.
        bus.IMEM_ACK    = 1'b1;
        bus.IMEM_RDATA  = 32'h40B50533;
        bus.PC_IN       = 64'h0;
        bus.FETCH_START = 1'b1;
        step();
        bus.FETCH_START = 1'b0;
        check_eq("hold.req", bus.IMEM_REQ, 1'b1);
        check_eq("hold.ir0", bus.IR31_0,   m_ir);
        step();
        bus.IMEM_ACK = 1'b0;
        m_ir      = 32'h40B50533;
        m_illegal = 1'b0;
        check_eq("hold.valid", bus.IR_VALID, 1'b1);
        check_eq("hold.f7",    bus.FUNCT7,   7'd32);
        check_eq("hold.rs2",   bus.IR24_20,  5'd11);
        check_eq("hold.op",    bus.IR6_0,    7'd51);
        check_ir("hold");
        step();
        check_idle("hold.end");

        fetch_misaligned("mis42", 64'h42);

        // Directed: unsupported opcode still produces a valid pulse.
        fetch_ok("ill", 64'h80, 0, 32'h0000007F);
        check_eq("ill.flag", bus.ILLEGAL_OP, 1'b1);

`ifdef FETCH_TIMEOUT_EN
        bus.PC_IN       = 64'h200;
        bus.FETCH_START = 1'b1;
        step();
        bus.FETCH_START = 1'b0;
        for (int i = 2; i <= int'(TMO); i++) begin
            step();
            check_eq("tmo.req", bus.IMEM_REQ, 1'b1);
        end
        step();
        check_eq("tmo.req0",  bus.IMEM_REQ,    1'b0);
        check_eq("tmo.fault", bus.FETCH_FAULT, 1'b1);
        check_eq("tmo.cause", bus.FAULT_CAUSE, 2'd2);
        check_ir("tmo");
        bus.FAULT_CLR = 1'b1;
        step();
        bus.FAULT_CLR = 1'b0;
        check_idle("tmo.clr");
        check_eq("tmo.cause0", bus.FAULT_CAUSE, 2'd0);
        fetch_ok("tie", 64'h204, int'(TMO) - 1, 32'h00112023);
        check_eq("tie.cause", bus.FAULT_CAUSE, 2'd0);
`else
        bus.PC_IN       = 64'h200;
        bus.FETCH_START = 1'b1;
        step();
        bus.FETCH_START = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq("notmo.req",   bus.IMEM_REQ,    1'b1);
            check_eq("notmo.cause", bus.FAULT_CAUSE, 2'd0);
        end
        capture_and_finish("notmo", 32'h00112023);
`endif

        // Reset while a request is outstanding.
        bus.PC_IN       = 64'h100;
        bus.FETCH_START = 1'b1;
        step();
        bus.FETCH_START = 1'b0;
        check_eq("rreq.req", bus.IMEM_REQ, 1'b1);
        #3;
        RESET = 1'b1;
        #1;
        m_ir      = '0;
        m_illegal = 1'b0;
        check_all_zero("rreq");
        step();
        RESET = 1'b0;
        step();
        fetch_ok("after_rst", 64'h104, 1, 32'h000000B7);

        // Randomized transactions with junk acks between them.
        for (int t = 0; t < 40; t++) begin
            pc = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) begin
                pc[1:0] = 2'($urandom_range(1, 3));
                fetch_misaligned("rnd_mis", pc);
            end else begin
                pc[1:0] = 2'b00;
                data    = $urandom;
                if ($urandom_range(0, 9) < 7) data[6:0] = 7'(legal_ops[$urandom_range(0, 6)]);
                w = int'($urandom_range(0, 10));
                fetch_ok("rnd", pc, w, data);
            end
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                bus.IMEM_ACK   = 1'b1;
                bus.IMEM_RDATA = $urandom;
                step();
                check_idle("gap");
                check_eq("gap.ir", bus.IR31_0, m_ir);
            end
            bus.IMEM_ACK = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
